// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared constants for the TinyRisc-V decode stage: ALU operation codes,
// operand/next-PC selects, CSR operation codes, RV32 opcodes and the packed
// decoded-instruction bundle carried from decode to execute.
// ---------------------------------------------------------------------------
package decode_stage_pkg;

    // ALU operations
    localparam int ALU_OP_WIDTH = 5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NONE   = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD    = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB    = 5'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL    = 5'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT    = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU   = 5'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR    = 5'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL    = 5'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA    = 5'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR     = 5'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND    = 5'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ    = 5'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE    = 5'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE    = 5'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU   = 5'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL    = 5'd15;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULH   = 5'd16;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULHSU = 5'd17;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULHU  = 5'd18;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV    = 5'd19;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_DIVU   = 5'd20;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_REM    = 5'd21;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_REMU   = 5'd22;

    // Operand A select
    localparam int SEL_SRC_A_WIDTH = 2;
    localparam logic [SEL_SRC_A_WIDTH-1:0] SEL_SRC_A_REG  = 2'd0;
    localparam logic [SEL_SRC_A_WIDTH-1:0] SEL_SRC_A_PC   = 2'd1;
    localparam logic [SEL_SRC_A_WIDTH-1:0] SEL_SRC_A_ZERO = 2'd2;

    // Operand B select
    localparam int SEL_SRC_B_WIDTH = 2;
    localparam logic [SEL_SRC_B_WIDTH-1:0] SEL_SRC_B_REG  = 2'd0;
    localparam logic [SEL_SRC_B_WIDTH-1:0] SEL_SRC_B_IMM  = 2'd1;
    localparam logic [SEL_SRC_B_WIDTH-1:0] SEL_SRC_B_FOUR = 2'd2;

    // Next-PC select
    localparam int SEL_PC_WIDTH = 3;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4   = 3'd0;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_BRANCH = 3'd1;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL    = 3'd2;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR   = 3'd3;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_MTVEC  = 3'd4;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_MEPC   = 3'd5;

    // CSR operations
    localparam int CSR_OP_WIDTH = 4;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_NONE  = 4'd0;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RW    = 4'd1;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RS    = 4'd2;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RC    = 4'd3;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RWI   = 4'd4;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RSI   = 4'd5;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_RCI   = 4'd6;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_ECALL = 4'd7;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_MRET  = 4'd8;

    localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;

    localparam logic [31:0] CODE_ECALL = 32'h0000_0073;
    localparam logic [31:0] CODE_MRET  = 32'h3020_0073;

    // RV32 major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [31:0]                pc;
        logic [31:0]                imm;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [4:0]                 rd;
        logic [ALU_OP_WIDTH-1:0]    alu_op;
        logic [SEL_SRC_A_WIDTH-1:0] src_a;
        logic [SEL_SRC_B_WIDTH-1:0] src_b;
        logic [SEL_PC_WIDTH-1:0]    pc_sel;
        logic                       wb_reg;
        logic [11:0]                csr_addr;
        logic [CSR_OP_WIDTH-1:0]    csr_op;
        logic                       csr_wb;
        logic                       illegal;
    } decode_bundle_t;

    localparam int BUNDLE_W = $bits(decode_bundle_t);

    // Register-register / register-immediate ALU op chosen by funct3 alone.
    // Shift-right comes back as SRL; callers refine it to SRA from funct7.
    function automatic logic [ALU_OP_WIDTH-1:0] base_alu_op(input logic [2:0] f3);
        logic [ALU_OP_WIDTH-1:0] op;
        case (f3)
            3'b000:  op = ALU_OP_ADD;
            3'b001:  op = ALU_OP_SLL;
            3'b010:  op = ALU_OP_SLT;
            3'b011:  op = ALU_OP_SLTU;
            3'b100:  op = ALU_OP_XOR;
            3'b101:  op = ALU_OP_SRL;
            3'b110:  op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// ---------------------------------------------------------------------------
// decode_logic
// Purely combinational RV32I (+ optional RV32M) decoder.
//   code    in  32  instruction word
//   pc      in  32  instruction PC (copied into the bundle)
//   bundle  out BUNDLE_W  packed decode_bundle_t
// Parameter ENABLE_M: nonzero decodes MUL..REMU, zero makes them illegal.
// ---------------------------------------------------------------------------
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [31:0]         code,
    input  logic [31:0]         pc,
    output logic [BUNDLE_W-1:0] bundle
);

    logic [6:0]  opcode;
    logic [4:0]  rd_f;
    logic [2:0]  f3;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt, imm_zimm;

    assign opcode = code[6:0];
    assign rd_f   = code[11:7];
    assign f3     = code[14:12];
    assign rs1_f  = code[19:15];
    assign rs2_f  = code[24:20];
    assign f7     = code[31:25];

    assign imm_i     = {{20{code[31]}}, code[31:20]};
    assign imm_s     = {{20{code[31]}}, code[31:25], code[11:7]};
    assign imm_b     = {{19{code[31]}}, code[31], code[7], code[30:25], code[11:8], 1'b0};
    assign imm_u     = {code[31:12], 12'b0};
    assign imm_j     = {{11{code[31]}}, code[31], code[19:12], code[20], code[30:21], 1'b0};
    assign imm_shamt = {27'b0, code[24:20]};
    assign imm_zimm  = {27'b0, code[19:15]};

    decode_bundle_t d;
    logic           ill;

    always_comb begin
        d        = '0;
        d.pc     = pc;
        ill      = 1'b0;

        case (opcode)
            OPC_LUI: begin
                d.rd     = rd_f;
                d.imm    = imm_u;
                d.alu_op = ALU_OP_ADD;
                d.src_a  = SEL_SRC_A_ZERO;
                d.src_b  = SEL_SRC_B_IMM;
                d.wb_reg = (rd_f != 5'd0);
            end
            OPC_AUIPC: begin
                d.rd     = rd_f;
                d.imm    = imm_u;
                d.alu_op = ALU_OP_ADD;
                d.src_a  = SEL_SRC_A_PC;
                d.src_b  = SEL_SRC_B_IMM;
                d.wb_reg = (rd_f != 5'd0);
            end
            OPC_JAL: begin
                // ALU produces the link value pc+4; target uses imm.
                d.rd     = rd_f;
                d.imm    = imm_j;
                d.alu_op = ALU_OP_ADD;
                d.src_a  = SEL_SRC_A_PC;
                d.src_b  = SEL_SRC_B_FOUR;
                d.pc_sel = SEL_PC_JAL;
                d.wb_reg = (rd_f != 5'd0);
            end
            OPC_JALR: begin
                ill      = (f3 != 3'b000);
                d.rd     = rd_f;
                d.rs1    = rs1_f;
                d.imm    = imm_i;
                d.alu_op = ALU_OP_ADD;
                d.src_a  = SEL_SRC_A_PC;
                d.src_b  = SEL_SRC_B_FOUR;
                d.pc_sel = SEL_PC_JALR;
                d.wb_reg = (rd_f != 5'd0);
            end
            OPC_BRANCH: begin
                d.rs1    = rs1_f;
                d.rs2    = rs2_f;
                d.imm    = imm_b;
                d.pc_sel = SEL_PC_BRANCH;
                case (f3)
                    3'b000:  d.alu_op = ALU_OP_SEQ;
                    3'b001:  d.alu_op = ALU_OP_SNE;
                    3'b100:  d.alu_op = ALU_OP_SLT;
                    3'b101:  d.alu_op = ALU_OP_SGE;
                    3'b110:  d.alu_op = ALU_OP_SLTU;
                    3'b111:  d.alu_op = ALU_OP_SGEU;
                    default: ill      = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                // ALU forms the effective address; the access width is
                // recovered downstream from funct3.
                ill      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                d.rd     = rd_f;
                d.rs1    = rs1_f;
                d.imm    = imm_i;
                d.alu_op = ALU_OP_ADD;
                d.src_b  = SEL_SRC_B_IMM;
                d.wb_reg = (rd_f != 5'd0);
            end
            OPC_STORE: begin
                ill      = (f3[2] == 1'b1) || (f3 == 3'b011);
                d.rs1    = rs1_f;
                d.rs2    = rs2_f;
                d.imm    = imm_s;
                d.alu_op = ALU_OP_ADD;
                d.src_b  = SEL_SRC_B_IMM;
            end
            OPC_OP_IMM: begin
                d.rd     = rd_f;
                d.rs1    = rs1_f;
                d.src_b  = SEL_SRC_B_IMM;
                d.wb_reg = (rd_f != 5'd0);
                d.alu_op = base_alu_op(f3);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.imm = imm_shamt;
                    if (f7 == 7'b0100000 && f3 == 3'b101) begin
                        d.alu_op = ALU_OP_SRA;
                    end else if (f7 != 7'b0000000) begin
                        ill = 1'b1;
                    end
                end else begin
                    d.imm = imm_i;
                end
            end
            OPC_OP: begin
                d.rd     = rd_f;
                d.rs1    = rs1_f;
                d.rs2    = rs2_f;
                d.wb_reg = (rd_f != 5'd0);
                if (f7 == 7'b0000000) begin
                    d.alu_op = base_alu_op(f3);
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'b000:  d.alu_op = ALU_OP_SUB;
                        3'b101:  d.alu_op = ALU_OP_SRA;
                        default: ill      = 1'b1;
                    endcase
                end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
                    case (f3)
                        3'b000:  d.alu_op = ALU_OP_MUL;
                        3'b001:  d.alu_op = ALU_OP_MULH;
                        3'b010:  d.alu_op = ALU_OP_MULHSU;
                        3'b011:  d.alu_op = ALU_OP_MULHU;
                        3'b100:  d.alu_op = ALU_OP_DIV;
                        3'b101:  d.alu_op = ALU_OP_DIVU;
                        3'b110:  d.alu_op = ALU_OP_REM;
                        default: d.alu_op = ALU_OP_REMU;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE on an in-order single-hart core is a no-op.
            end
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    if (code == CODE_ECALL) begin
                        d.csr_op   = CSR_OP_ECALL;
                        d.csr_addr = CSR_ADDR_MCAUSE;
                        d.csr_wb   = 1'b1;
                        d.pc_sel   = SEL_PC_MTVEC;
                    end else if (code == CODE_MRET) begin
                        d.csr_op   = CSR_OP_MRET;
                        d.pc_sel   = SEL_PC_MEPC;
                    end else begin
                        ill = 1'b1;
                    end
                end else if (f3 == 3'b100) begin
                    ill = 1'b1;
                end else begin
                    d.csr_addr = code[31:20];
                    d.rd       = rd_f;
                    d.wb_reg   = (rd_f != 5'd0);
                    // Set/clear with a zero mask must not write the CSR.
                    d.csr_wb   = (f3[1:0] == 2'b01) || (rs1_f != 5'd0);
                    if (f3[2]) begin
                        d.imm = imm_zimm;
                    end else begin
                        d.rs1 = rs1_f;
                    end
                    case (f3)
                        3'b001:  d.csr_op = CSR_OP_RW;
                        3'b010:  d.csr_op = CSR_OP_RS;
                        3'b011:  d.csr_op = CSR_OP_RC;
                        3'b101:  d.csr_op = CSR_OP_RWI;
                        3'b110:  d.csr_op = CSR_OP_RSI;
                        default: d.csr_op = CSR_OP_RCI;
                    endcase
                end
            end
            default: ill = 1'b1;
        endcase

        // An illegal instruction carries only its PC and the flag, so
        // execute sees no side effects and can raise the trap cleanly.
        if (ill) begin
            d         = '0;
            d.pc      = pc;
            d.illegal = 1'b1;
        end
    end

    assign bundle = d;

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered, flow-controlled decode stage between fetch and execute.
// Instructions are decoded combinationally on entry and stored in a
// DEPTH-entry circular queue whose head drives the out_* ports.
//   clk, rst_n             clock / asynchronous active-low reset
//   flush                  redirect: empties the queue, drops same-cycle input
//   in_valid/in_ready      fetch handshake; in_code, in_pc payload
//   out_valid/out_ready    execute handshake on the queue head
//   out_pc..out_illegal    decoded fields of the head entry (0 when empty)
// Parameters: DEPTH (power of two, >= 2), ENABLE_M (RV32M decode).
// ---------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int ENABLE_M = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_code,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_imm,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [ALU_OP_WIDTH-1:0]    out_alu_op,
    output logic [SEL_SRC_A_WIDTH-1:0] out_src_a,
    output logic [SEL_SRC_B_WIDTH-1:0] out_src_b,
    output logic [SEL_PC_WIDTH-1:0]    out_pc_sel,
    output logic                       out_wb_reg,
    output logic [11:0]                out_csr_addr,
    output logic [CSR_OP_WIDTH-1:0]    out_csr_op,
    output logic                       out_csr_wb,
    output logic                       out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // ---- stage p0: combinational decode of the offered instruction ----
    logic [BUNDLE_W-1:0] dec_bits_p0;
    decode_bundle_t      dec_p0;

    decode_logic #(
        .ENABLE_M (ENABLE_M)
    ) u_decode_logic (
        .code   (in_code),
        .pc     (in_pc),
        .bundle (dec_bits_p0)
    );

    assign dec_p0 = dec_bits_p0;

    // ---- stage p1: decoded-bundle queue ----
    decode_bundle_t   fifo_p1 [DEPTH];
    decode_bundle_t   head_p1;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             vld_p1;
    logic             push;
    logic             pop;

    assign vld_p1   = (count != '0);
    // Full queue still accepts when the head leaves in the same cycle.
    assign in_ready = (count != CNT_FULL) || out_ready;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = vld_p1 && out_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_p1[i] <= '0;
            end
        end else if (push) begin
            fifo_p1[wr_ptr] <= dec_p0;
        end
    end

    assign head_p1 = vld_p1 ? fifo_p1[rd_ptr] : '0;

    assign out_valid    = vld_p1;
    assign out_pc       = head_p1.pc;
    assign out_imm      = head_p1.imm;
    assign out_rs1      = head_p1.rs1;
    assign out_rs2      = head_p1.rs2;
    assign out_rd       = head_p1.rd;
    assign out_alu_op   = head_p1.alu_op;
    assign out_src_a    = head_p1.src_a;
    assign out_src_b    = head_p1.src_b;
    assign out_pc_sel   = head_p1.pc_sel;
    assign out_wb_reg   = head_p1.wb_reg;
    assign out_csr_addr = head_p1.csr_addr;
    assign out_csr_op   = head_p1.csr_op;
    assign out_csr_wb   = head_p1.csr_wb;
    assign out_illegal  = head_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Directed-vector bench for decode_stage. u_dut is DEPTH=2, ENABLE_M=0;
// u_dut_m is the same with ENABLE_M=1 and shares every input.
// ---------------------------------------------------------------------------
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_code;
    logic [31:0] in_pc;
    logic        out_ready;

    logic                       o_in_ready, o_valid, o_wb_reg, o_csr_wb, o_illegal;
    logic [31:0]                o_pc, o_imm;
    logic [4:0]                 o_rs1, o_rs2, o_rd;
    logic [ALU_OP_WIDTH-1:0]    o_alu_op;
    logic [SEL_SRC_A_WIDTH-1:0] o_src_a;
    logic [SEL_SRC_B_WIDTH-1:0] o_src_b;
    logic [SEL_PC_WIDTH-1:0]    o_pc_sel;
    logic [11:0]                o_csr_addr;
    logic [CSR_OP_WIDTH-1:0]    o_csr_op;

    logic                       m_in_ready, m_valid, m_wb_reg, m_csr_wb, m_illegal;
    logic [31:0]                m_pc, m_imm;
    logic [4:0]                 m_rs1, m_rs2, m_rd;
    logic [ALU_OP_WIDTH-1:0]    m_alu_op;
    logic [SEL_SRC_A_WIDTH-1:0] m_src_a;
    logic [SEL_SRC_B_WIDTH-1:0] m_src_b;
    logic [SEL_PC_WIDTH-1:0]    m_pc_sel;
    logic [11:0]                m_csr_addr;
    logic [CSR_OP_WIDTH-1:0]    m_csr_op;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.DEPTH(2), .ENABLE_M(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o_in_ready), .in_code(in_code), .in_pc(in_pc),
        .out_valid(o_valid), .out_ready(out_ready), .out_pc(o_pc), .out_imm(o_imm),
        .out_rs1(o_rs1), .out_rs2(o_rs2), .out_rd(o_rd), .out_alu_op(o_alu_op),
        .out_src_a(o_src_a), .out_src_b(o_src_b), .out_pc_sel(o_pc_sel),
        .out_wb_reg(o_wb_reg), .out_csr_addr(o_csr_addr), .out_csr_op(o_csr_op),
        .out_csr_wb(o_csr_wb), .out_illegal(o_illegal)
    );

    decode_stage #(.DEPTH(2), .ENABLE_M(1)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_code(in_code), .in_pc(in_pc),
        .out_valid(m_valid), .out_ready(out_ready), .out_pc(m_pc), .out_imm(m_imm),
        .out_rs1(m_rs1), .out_rs2(m_rs2), .out_rd(m_rd), .out_alu_op(m_alu_op),
        .out_src_a(m_src_a), .out_src_b(m_src_b), .out_pc_sel(m_pc_sel),
        .out_wb_reg(m_wb_reg), .out_csr_addr(m_csr_addr), .out_csr_op(m_csr_op),
        .out_csr_wb(m_csr_wb), .out_illegal(m_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Head-entry register/immediate/ALU fields of u_dut.
    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [ALU_OP_WIDTH-1:0] alu, input logic wb, input logic ill);
        chk({tag, ".valid"},   32'(o_valid),   32'd1);
        chk({tag, ".pc"},      o_pc,           pc);
        chk({tag, ".imm"},     o_imm,          imm);
        chk({tag, ".rs1"},     32'(o_rs1),     32'(rs1));
        chk({tag, ".rs2"},     32'(o_rs2),     32'(rs2));
        chk({tag, ".rd"},      32'(o_rd),      32'(rd));
        chk({tag, ".alu"},     32'(o_alu_op),  32'(alu));
        chk({tag, ".wb"},      32'(o_wb_reg),  32'(wb));
        chk({tag, ".illegal"}, 32'(o_illegal), 32'(ill));
    endtask

    // Offer one instruction for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] code, input logic [31:0] pc);
        in_valid = 1'b1;
        in_code  = code;
        in_pc    = pc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        #1;
        chk("rst.out_valid", 32'(o_valid),    32'd0);
        chk("rst.in_ready",  32'(o_in_ready), 32'd1);
        chk("rst.pc",        o_pc,            32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming decode with execute always ready
        issue(32'h0050_0093, 32'h100);                       // addi x1,x0,5
        chk_head("addi", 32'h100, 32'd5, 5'd0, 5'd0, 5'd1, ALU_OP_ADD, 1'b1, 1'b0);
        chk("addi.src_a",  32'(o_src_a),  32'(SEL_SRC_A_REG));
        chk("addi.src_b",  32'(o_src_b),  32'(SEL_SRC_B_IMM));
        chk("addi.pc_sel", 32'(o_pc_sel), 32'(SEL_PC_ADD4));

        issue(32'h4020_D1B3, 32'h104);                       // sra x3,x1,x2
        chk_head("sra", 32'h104, 32'd0, 5'd1, 5'd2, 5'd3, ALU_OP_SRA, 1'b1, 1'b0);
        chk("sra.src_b", 32'(o_src_b), 32'(SEL_SRC_B_REG));
        issue(32'h0020_D1B3, 32'h108);                       // srl x3,x1,x2
        chk_head("srl", 32'h108, 32'd0, 5'd1, 5'd2, 5'd3, ALU_OP_SRL, 1'b1, 1'b0);
        issue(32'h4020_81B3, 32'h10C);                       // sub x3,x1,x2
        chk_head("sub", 32'h10C, 32'd0, 5'd1, 5'd2, 5'd3, ALU_OP_SUB, 1'b1, 1'b0);

        issue(32'h0220_81B3, 32'h110);                       // mul x3,x1,x2
        chk_head("mul_m0", 32'h110, 32'd0, 5'd0, 5'd0, 5'd0, ALU_OP_NONE, 1'b0, 1'b1);
        chk("mul_m0.pc_sel", 32'(o_pc_sel),   32'(SEL_PC_ADD4));
        chk("mul_m1.valid",  32'(m_valid),    32'd1);
        chk("mul_m1.ready",  32'(m_in_ready), 32'd1);
        chk("mul_m1.pc",     m_pc,            32'h110);
        chk("mul_m1.imm",    m_imm,           32'd0);
        chk("mul_m1.rs1",    32'(m_rs1),      32'd1);
        chk("mul_m1.rs2",    32'(m_rs2),      32'd2);
        chk("mul_m1.rd",     32'(m_rd),       32'd3);
        chk("mul_m1.alu",    32'(m_alu_op),   32'(ALU_OP_MUL));
        chk("mul_m1.src_a",  32'(m_src_a),    32'(SEL_SRC_A_REG));
        chk("mul_m1.src_b",  32'(m_src_b),    32'(SEL_SRC_B_REG));
        chk("mul_m1.pc_sel", 32'(m_pc_sel),   32'(SEL_PC_ADD4));
        chk("mul_m1.wb",     32'(m_wb_reg),   32'd1);
        chk("mul_m1.caddr",  32'(m_csr_addr), 32'd0);
        chk("mul_m1.cop",    32'(m_csr_op),   32'(CSR_OP_NONE));
        chk("mul_m1.cwb",    32'(m_csr_wb),   32'd0);
        chk("mul_m1.ill",    32'(m_illegal),  32'd0);

        issue(32'hFFF0_0093, 32'h114);                       // addi x1,x0,-1
        chk_head("addi_neg", 32'h114, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd1, ALU_OP_ADD, 1'b1, 1'b0);
        issue(32'h0020_A623, 32'h118);                       // sw x2,12(x1)
        chk_head("sw", 32'h118, 32'd12, 5'd1, 5'd2, 5'd0, ALU_OP_ADD, 1'b0, 1'b0);

        issue(32'h0000_0073, 32'h11C);                       // ecall
        chk("ecall.cop",    32'(o_csr_op),   32'(CSR_OP_ECALL));
        chk("ecall.caddr",  32'(o_csr_addr), 32'h342);
        chk("ecall.pc_sel", 32'(o_pc_sel),   32'(SEL_PC_MTVEC));
        chk("ecall.cwb",    32'(o_csr_wb),   32'd1);
        chk("ecall.wb",     32'(o_wb_reg),   32'd0);
        issue(32'h3020_0073, 32'h120);                       // mret
        chk("mret.cop",    32'(o_csr_op), 32'(CSR_OP_MRET));
        chk("mret.pc_sel", 32'(o_pc_sel), 32'(SEL_PC_MEPC));
        chk("mret.cwb",    32'(o_csr_wb), 32'd0);
        issue(32'h3000_22F3, 32'h124);                       // csrrs x5,mstatus,x0
        chk("csrrs0.cop",   32'(o_csr_op),   32'(CSR_OP_RS));
        chk("csrrs0.caddr", 32'(o_csr_addr), 32'h300);
        chk("csrrs0.cwb",   32'(o_csr_wb),   32'd0);
        chk("csrrs0.wb",    32'(o_wb_reg),   32'd1);
        chk("csrrs0.rd",    32'(o_rd),       32'd5);

        issue(32'h0020_A063, 32'h128);                       // branch funct3=010
        chk_head("br010", 32'h128, 32'd0, 5'd0, 5'd0, 5'd0, ALU_OP_NONE, 1'b0, 1'b1);
        chk("br010.pc_sel", 32'(o_pc_sel), 32'(SEL_PC_ADD4));
        issue(32'h0000_4073, 32'h12C);                       // SYSTEM funct3=100
        chk("sys100.illegal", 32'(o_illegal), 32'd1);
        chk("sys100.cwb",     32'(o_csr_wb),  32'd0);
        @(posedge clk);
        #1;
        chk("drain.valid", 32'(o_valid), 32'd0);

        // Back-pressure on a full DEPTH=2 queue, then push+pop while full
        out_ready = 1'b0;
        issue(32'h0010_0093, 32'h200);
        issue(32'h0020_0093, 32'h204);
        in_valid = 1'b1;
        in_code  = 32'h0030_0093;
        in_pc    = 32'h208;
        chk("full.in_ready", 32'(o_in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("stall.in_ready", 32'(o_in_ready), 32'd0);
        chk("stall.head_pc",  o_pc,            32'h200);
        chk("stall.head_imm", o_imm,           32'd1);
        out_ready = 1'b1;
        #1;
        chk("full_pop.in_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pushpop.head_pc", o_pc,            32'h204);
        chk("pushpop.valid",   32'(o_valid),    32'd1);
        @(posedge clk);
        #1;
        chk("wrap.head_pc",  o_pc,  32'h208);
        chk("wrap.head_imm", o_imm, 32'd3);
        @(posedge clk);
        #1;
        chk("wrap.empty", 32'(o_valid), 32'd0);

        // Flush with a full queue, a same-cycle input and a same-cycle pop
        out_ready = 1'b0;
        issue(32'h0010_0093, 32'h300);
        issue(32'h0020_0093, 32'h304);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_code   = 32'h0030_0093;
        in_pc     = 32'h308;
        #1;
        chk("flush.in_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("flush.dropped", 32'(o_valid), 32'd0);
        issue(32'h0040_0093, 32'h400);
        chk("post_flush.pc", o_pc, 32'h400);

        // Asynchronous reset in mid-stream
        out_ready = 1'b0;
        issue(32'h0010_0093, 32'h500);
        issue(32'h0020_0093, 32'h504);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.valid",    32'(o_valid),    32'd0);
        chk("arst.in_ready", 32'(o_in_ready), 32'd1);
        chk("arst.pc",       o_pc,            32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.still_empty", 32'(o_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
